// File: rtl/pfc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pfc_pkg
// Brief    : Shared types and constants for the parity frame checker.
// Revision : 1.0
// ============================================================================
package pfc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } pfc_state_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    // Wide enough to hold DATA_BITS itself, so the count never wraps mid-frame.
    function automatic int cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/parity_acc.sv
`default_nettype none
// ============================================================================
// Module   : parity_acc
// Brief    : 1-bit running XOR register with synchronous clear and enable.
// Revision : 1.0
// ============================================================================
module parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic par
);

    logic r_par;

    // Clear takes priority so a restart in the same cycle as a bit drops that bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (clr) begin
            r_par <= 1'b0;
        end else if (en) begin
            r_par <= r_par ^ bit_in;
        end
    end

    assign par = r_par;

endmodule
`default_nettype wire

// File: rtl/parity_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_checker
// Brief    : Serial LSB-first payload receiver with trailing parity check.
//            Define PFC_ERR_CNT_EN to build the saturating error counter.
// Revision : 1.0
// ============================================================================
module parity_frame_checker
    import pfc_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 parity_err,
    output logic                 frame_abort,
    output logic [DATA_BITS-1:0] data_out,
    output logic [7:0]           err_cnt
);

    localparam int             CNT_W      = cnt_width(DATA_BITS);
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_BITS - 1);
    localparam logic           c_odd      = (ODD_PARITY != 0);

    pfc_state_t           r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_abort;
    logic                 r_err;

    logic                 w_par;
    logic                 w_acc_en;
    logic                 w_bit_err;

    assign w_acc_en  = !start && bit_valid && (r_state == DATA);
    assign w_bit_err = (bit_in != (w_par ^ c_odd));

    parity_acc u_parity_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start),
        .en     (w_acc_en),
        .bit_in (bit_in),
        .par    (w_par)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            if (start) begin
                // Restart from any state; a partial frame is simply discarded.
                r_abort <= (r_state != IDLE);
                r_state <= DATA;
                r_busy  <= 1'b1;
                r_shift <= '0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_busy <= 1'b0;
                    end
                    DATA: begin
                        if (bit_valid) begin
                            r_shift <= {bit_in, r_shift[DATA_BITS-1:1]};
                            r_cnt   <= r_cnt + 1'b1;
                            if (r_cnt == c_last_bit) begin
                                r_state <= PAR;
                            end
                        end
                    end
                    PAR: begin
                        if (bit_valid) begin
                            r_data  <= r_shift;
                            r_err   <= w_bit_err;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy        = r_busy;
    assign frame_done  = r_done;
    assign frame_abort = r_abort;
    assign parity_err  = r_err;
    assign data_out    = r_data;

`ifdef PFC_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    logic       w_cnt_inc;

    assign w_cnt_inc = !start && bit_valid && (r_state == PAR) && w_bit_err
                       && (r_err_cnt != ERR_CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_cnt_inc) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire
